frac_divider_core: RTL and testbench

//  Sequential restoring divider for normalized unsigned binary fractions.

---
 rtl/frac_divider_if.sv | 45 ++++
 rtl/frac_divider_core.sv | 130 +++++++++++++
 tb/tb_frac_divider_core.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frac_divider_if.sv
// -----------------------------------------------------------------------------
// frac_divider_if
// Handshake and data bundle between a requester and frac_divider_core.
//
// Signals
//   start  requester -> divider  one-cycle pulse, a/b sampled on this edge only
//   a      requester -> divider  dividend fraction 0.a (ni bits)
//   b      requester -> divider  divisor fraction 0.b (ni bits)
//   q      divider -> requester  quotient, q[no] integer bit, q[no-1:0] fraction
//   busy   divider -> requester  high while a division is iterating
//   done   divider -> requester  one-cycle pulse when q takes a new result
//
// Modports
//   master  requester side (drives start/a/b)
//   slave   divider side (drives q/busy/done)
// -----------------------------------------------------------------------------
interface frac_divider_if #(
    parameter int ni = 32,
    parameter int no = 40
);
    logic          start;
    logic [ni-1:0] a;
    logic [ni-1:0] b;
    logic [no:0]   q;
    logic          busy;
    logic          done;

    modport master (
        output start,
        output a,
        output b,
        input  q,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output q,
        output busy,
        output done
    );
endinterface

// File: rtl/frac_divider_core.sv
// -----------------------------------------------------------------------------
// frac_divider_core
// Sequential restoring divider for normalized unsigned binary fractions.
// Computes q = floor(a * 2^no / b), one quotient bit per clock, MSB (integer
// bit) first. The result register only changes when a division completes.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (wins over start, aborts any op)
//   bus   slave modport of frac_divider_if:
//           start/a/b in, q/busy/done out (all outputs registered)
//
// Parameters
//   ni  operand width (a[ni-1] has weight 2^-1)
//   no  number of quotient fraction bits
// -----------------------------------------------------------------------------
module frac_divider_core #(
    parameter int ni = 32,
    parameter int no = 40
) (
    input  logic           clk,
    input  logic           rst,
    frac_divider_if.slave  bus
);

    // Enough counter bits to hold no (no+1 steps counted down to zero).
    localparam int CW = $clog2(no + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [ni:0]   rem_q,   rem_d;
    logic [ni-1:0] div_q,   div_d;
    logic [no-1:0] work_q,  work_d;
    logic [no:0]   result_q, result_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic          qbit_s;
    logic [ni:0]   rem_next_s;

    // One restoring step: trial-subtract the divisor, keep the difference only
    // when it does not go negative, then shift for the next quotient bit.
    // The shift drops the top bit; for normalized operands R < 2B keeps it zero,
    // and for out-of-range operands the wrap is the documented truncation.
    always_comb begin
        qbit_s     = 1'b0;
        rem_next_s = rem_q;
        if (rem_q >= {1'b0, div_q}) begin
            qbit_s     = 1'b1;
            rem_next_s = (rem_q - {1'b0, div_q}) << 1;
        end else begin
            qbit_s     = 1'b0;
            rem_next_s = rem_q << 1;
        end
    end

    // Next-state logic: start (re)loads the operands and always takes priority
    // over an in-flight division, so an aborted op never raises done.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        div_d    = div_q;
        work_d   = work_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (bus.start) begin
            state_d = RUN;
            cnt_d   = CW'(no);
            rem_d   = {1'b0, bus.a};
            div_d   = bus.b;
            work_d  = {no{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    rem_d = rem_next_s;
                    if (cnt_q == {CW{1'b0}}) begin
                        // Final step: the working register holds the first no
                        // bits, this cycle's bit completes the quotient.
                        state_d  = IDLE;
                        result_d = {work_q, qbit_s};
                        done_d   = 1'b1;
                        work_d   = work_q;
                    end else begin
                        cnt_d  = cnt_q - CW'(1);
                        work_d = {work_q[no-2:0], qbit_s};
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d == RUN);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            rem_q    <= {(ni + 1){1'b0}};
            div_q    <= {ni{1'b0}};
            work_q   <= {no{1'b0}};
            result_q <= {(no + 1){1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            work_q   <= work_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.q    = result_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_frac_divider_core.sv
// -----------------------------------------------------------------------------
// tb_frac_divider_core
// Directed and random checks of frac_divider_core (ni=32, no=40).
// -----------------------------------------------------------------------------
module tb_frac_divider_core;

    localparam int NI = 32;
    localparam int NO = 40;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    frac_divider_if #(.ni(NI), .no(NO)) bus ();

    frac_divider_core #(.ni(NI), .no(NO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start with the given operands, then wait (bounded) for done.
    // Returns the quotient seen with done, the edge count from the start edge
    // (-1 on timeout) and whether q stayed stable while the op was running.
    task automatic do_op(input logic [NI-1:0] av, input logic [NI-1:0] bv,
                         output logic [NO:0] qv, output int lat, output bit held);
        logic [NO:0] prev;
        @(negedge clk);
        prev       = bus.q;
        bus.start  = 1'b1;
        bus.a      = av;
        bus.b      = bv;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.a      = 'x;
        bus.b      = 'x;
        lat  = -1;
        held = 1'b1;
        qv   = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = n;
                qv  = bus.q;
                break;
            end
            if (bus.q !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'h8000_0000;
        bus.b     = 32'h8000_0000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.q !== 41'h0) begin
            n_fail++; $display("FAIL reset_q: got %h expected %h", bus.q, 41'h0);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy (start with rst): got %b expected 0", bus.busy);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done);
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_basic();
        logic [NI-1:0] va [3];
        logic [NI-1:0] vb [3];
        logic [NO:0]   vq [3];
        logic [NO:0]   qv;
        int            lat;
        bit            held;
        va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; vq[0] = 41'h100_0000_0000;
        va[1] = 32'hC000_0000; vb[1] = 32'h8000_0000; vq[1] = 41'h180_0000_0000;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'h8000_0000; vq[2] = 41'h1FF_FFFF_FE00;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], qv, lat, held);
            n_checks++;
            if (lat !== 41) begin
                n_fail++; $display("FAIL basic_latency[%0d]: got %0d expected 41", i, lat);
            end
            n_checks++;
            if (qv !== vq[i]) begin
                n_fail++; $display("FAIL basic_q[%0d]: got %h expected %h", i, qv, vq[i]);
            end
            n_checks++;
            if (!held) begin
                n_fail++; $display("FAIL basic_hold[%0d]: q changed during run, expected stable", i);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== vq[i]) begin
                n_fail++;
                $display("FAIL basic_after[%0d]: done=%b busy=%b q=%h expected done=0 busy=0 q=%h",
                         i, bus.done, bus.busy, bus.q, vq[i]);
            end
        end
    endtask

    task automatic test_truncation();
        logic [NO:0] qv;
        int          lat;
        bit          held;
        do_op(32'h8000_0000, 32'hFFFF_FFFF, qv, lat, held);
        n_checks++;
        if (qv !== 41'h080_0000_0080 || lat !== 41) begin
            n_fail++;
            $display("FAIL truncation: q=%h lat=%0d expected q=%h lat=41", qv, lat, 41'h080_0000_0080);
        end
    endtask

    task automatic test_nonnormalized();
        logic [NO:0] qv;
        int          lat;
        bit          held;
        do_op(32'h1234_5678, 32'h0000_0000, qv, lat, held);
        n_checks++;
        if (qv !== 41'h1FF_FFFF_FFFF || lat !== 41) begin
            n_fail++;
            $display("FAIL div_by_zero: q=%h lat=%0d expected q=%h lat=41", qv, lat, 41'h1FF_FFFF_FFFF);
        end
        do_op(32'h0000_0000, 32'h8000_0000, qv, lat, held);
        n_checks++;
        if (qv !== 41'h0 || lat !== 41) begin
            n_fail++; $display("FAIL zero_dividend: q=%h lat=%0d expected q=0 lat=41", qv, lat);
        end
    endtask

    task automatic test_mid_reset();
        logic [NO:0] qv;
        int          lat;
        bit          held;
        bit          saw_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hC000_0000;
        bus.b     = 32'h8000_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.q !== 41'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: q=%h busy=%b done=%b expected 0/0/0", bus.q, bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++; $display("FAIL mid_reset_no_done: got done after reset, expected none");
        end
        do_op(32'hFFFF_FFFF, 32'h8000_0000, qv, lat, held);
        n_checks++;
        if (qv !== 41'h1FF_FFFF_FE00 || lat !== 41) begin
            n_fail++;
            $display("FAIL after_reset_op: q=%h lat=%0d expected q=%h lat=41", qv, lat, 41'h1FF_FFFF_FE00);
        end
    endtask

    task automatic test_back_to_back();
        logic [NO:0] qv;
        int          lat;
        bit          held;
        bit          saw_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h8000_0000;
        bus.b     = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        saw_done  = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        do_op(32'hC000_0000, 32'h8000_0000, qv, lat, held);
        n_checks++;
        if (saw_done || !held) begin
            n_fail++;
            $display("FAIL restart_abort: saw_done=%b held=%b expected 0/1", saw_done, held);
        end
        n_checks++;
        if (qv !== 41'h180_0000_0000 || lat !== 41) begin
            n_fail++;
            $display("FAIL restart_q: q=%h lat=%0d expected q=%h lat=41", qv, lat, 41'h180_0000_0000);
        end
    endtask

    task automatic test_random();
        logic [NO:0]    qv;
        logic [NO:0]    exp_q;
        logic [NI+NO-1:0] num;
        logic [NI+NO-1:0] quo;
        logic [NI-1:0]  ra;
        logic [NI-1:0]  rb;
        int             lat;
        bit             held;
        int             errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            ra = $urandom();
            rb = $urandom();
            ra[NI-1] = 1'b1;
            rb[NI-1] = 1'b1;
            num   = {ra, {NO{1'b0}}};
            quo   = num / {{NO{1'b0}}, rb};
            exp_q = quo[NO:0];
            do_op(ra, rb, qv, lat, held);
            if (qv !== exp_q || lat !== 41) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d]: a=%h b=%h q=%h lat=%0d expected q=%h lat=41",
                             i, ra, rb, qv, lat, exp_q);
            end
        end
        n_checks++;
        if (errs !== 0) begin
            n_fail++; $display("FAIL random_total: %0d errors expected 0", errs);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_basic();
        test_truncation();
        test_nonnormalized();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
